// File: rtl/tdm_demux_1x16.sv
// tdm_demux_1x16: 1-to-16 TDM receive demultiplexer.
// Collects slot beats into a shadow frame and publishes whole frames on dout.
module tdm_demux_1x16 #(
  parameter int DATA_W = 1,
  parameter int SLOTS  = 16,
  parameter int SEL_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      din_valid,
  input  logic [DATA_W-1:0]         din,
  input  logic                      frame_sync,
  output logic [SLOTS*DATA_W-1:0]   dout,
  output logic                      dout_valid,
  output logic [SEL_W-1:0]          slot,
  output logic                      locked,
  output logic                      sync_err
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(SLOTS - 1);
  localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);

  state_t                    state_q, state_d;
  logic [SEL_W-1:0]          slot_q, slot_d;
  logic [SLOTS*DATA_W-1:0]   shadow_q, shadow_d;
  logic [SLOTS*DATA_W-1:0]   dout_q, dout_d;
  logic                      dout_valid_q, dout_valid_d;
  logic                      sync_err_q, sync_err_d;

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    shadow_d     = shadow_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sync_err_d   = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (frame_sync) begin
            shadow_d[DATA_W-1:0] = din;
            slot_d  = ONE;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          unique case (1'b1)
            (slot_q == '0) && frame_sync: begin
              shadow_d[DATA_W-1:0] = din;
              slot_d = ONE;
            end
            (slot_q == '0) && !frame_sync: begin
              sync_err_d = 1'b1;
              slot_d     = '0;
              state_d    = HUNT;
            end
            (slot_q != '0) && frame_sync: begin
              // early sync restarts the frame at this beat
              sync_err_d = 1'b1;
              shadow_d[DATA_W-1:0] = din;
              slot_d = ONE;
            end
            default: begin
              shadow_d[int'(slot_q)*DATA_W +: DATA_W] = din;
              slot_d = slot_q + ONE;
              if (slot_q == LAST) begin
                dout_d       = shadow_d;
                dout_valid_d = 1'b1;
                slot_d       = '0;
              end
            end
          endcase
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      slot_q       <= '0;
      shadow_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      shadow_q     <= shadow_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign slot       = slot_q;
  assign locked     = (state_q == LOCKED);
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1x16.sv
// tb_tdm_demux_1x16: vector table, directed corner cases and random
// stimulus checked against a frame-queue reference model.
module tb_tdm_demux_1x16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_valid = 1'b0;
  logic [0:0]  din = 1'b0;
  logic        frame_sync = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic [3:0]  slot;
  logic        locked;
  logic        sync_err;

  int total = 0;
  int bad = 0;

  tdm_demux_1x16 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din        (din),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  // reference model: the partial frame is a queue of received beats
  logic        m_locked;
  logic [15:0] m_dout;
  logic        m_valid;
  logic        m_err;
  logic        q[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_dout   = '0;
    m_valid  = 1'b0;
    m_err    = 1'b0;
    q.delete();
  endtask

  task automatic model_beat(input logic dv, input logic d, input logic fs);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (!dv) return;
    if (!m_locked) begin
      if (fs) begin
        m_locked = 1'b1;
        q = '{d};
      end
    end else if (q.size() == 0) begin
      if (fs) q = '{d};
      else begin
        m_err = 1'b1;
        m_locked = 1'b0;
      end
    end else if (fs) begin
      m_err = 1'b1;
      q = '{d};
    end else begin
      q.push_back(d);
      if (q.size() == 16) begin
        for (int i = 0; i < 16; i++) m_dout[i] = q[i];
        m_valid = 1'b1;
        q.delete();
      end
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, ".dout"}, int'(dout), int'(m_dout));
    chk({tag, ".valid"}, int'(dout_valid), int'(m_valid));
    chk({tag, ".err"}, int'(sync_err), int'(m_err));
    chk({tag, ".locked"}, int'(locked), int'(m_locked));
    chk({tag, ".slot"}, int'(slot), m_locked ? q.size() : 0);
  endtask

  task automatic step(input logic dv, input logic d, input logic fs,
                      input string tag);
    din_valid  = dv;
    din        = d;
    frame_sync = fs;
    @(posedge clk);
    model_beat(dv, d, fs);
    #1;
    compare(tag);
  endtask

  task automatic send_frame(input logic [15:0] pat, input bit gaps,
                            input string tag);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        int n = $urandom_range(0, 3);
        for (int g = 0; g < n; g++) step(1'b0, 1'b1, 1'b1, tag);
      end
      step(1'b1, pat[i], i == 0, tag);
    end
  endtask

  typedef struct {
    logic       dv;
    logic       d;
    logic       fs;
    logic       e_valid;
    logic       e_err;
    logic       e_locked;
    logic [3:0] e_slot;
  } vec_t;

  vec_t vt[7];

  initial begin
    vt[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1};
    vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1};
    vt[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2};
    vt[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1};
    vt[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1};
    vt[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2};

    model_reset();
    #12;
    chk("rst.dout", int'(dout), 0);
    chk("rst.valid", int'(dout_valid), 0);
    chk("rst.err", int'(sync_err), 0);
    chk("rst.locked", int'(locked), 0);
    chk("rst.slot", int'(slot), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      step(vt[i].dv, vt[i].d, vt[i].fs, "vec");
      chk($sformatf("vec%0d.valid", i), int'(dout_valid), int'(vt[i].e_valid));
      chk($sformatf("vec%0d.err", i), int'(sync_err), int'(vt[i].e_err));
      chk($sformatf("vec%0d.locked", i), int'(locked), int'(vt[i].e_locked));
      chk($sformatf("vec%0d.slot", i), int'(slot), int'(vt[i].e_slot));
    end

    // resync cleanly: missing sync at slot 0 is avoided by finishing this frame
    for (int i = 2; i < 16; i++) step(1'b1, 1'b0, 1'b0, "fill");

    // one-hot frames, back to back
    for (int k = 0; k < 16; k++) begin
      send_frame(16'(1 << k), 1'b0, "onehot");
      chk("onehot.dout", int'(dout), 1 << k);
      chk("onehot.valid", int'(dout_valid), 1);
      chk("onehot.wrap", int'(slot), 0);
      chk("onehot.locked", int'(locked), 1);
    end
    step(1'b0, 1'b0, 1'b0, "idle");
    chk("pulse.width", int'(dout_valid), 0);

    // gapped frame, alternating data
    send_frame(16'h5555, 1'b1, "gaps");
    chk("gaps.dout", int'(dout), 16'h5555);
    chk("gaps.valid", int'(dout_valid), 1);

    // early sync at slot 7
    send_frame(16'hA5A5, 1'b0, "a5");
    chk("a5.dout", int'(dout), 16'hA5A5);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, i == 0, "part");
    step(1'b1, 1'b0, 1'b1, "early");
    chk("early.err", int'(sync_err), 1);
    chk("early.dout", int'(dout), 16'hA5A5);
    chk("early.slot", int'(slot), 1);
    for (int i = 1; i < 16; i++) step(1'b1, i[0], 1'b0, "refr");
    chk("refr.dout", int'(dout), 16'hAAAA);
    chk("refr.valid", int'(dout_valid), 1);

    // missing sync at slot 0
    step(1'b1, 1'b1, 1'b0, "miss");
    chk("miss.err", int'(sync_err), 1);
    chk("miss.locked", int'(locked), 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, "nosync");
    chk("nosync.err", int'(sync_err), 0);
    chk("nosync.locked", int'(locked), 0);

    // asynchronous reset mid-frame at slot 9
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, i == 0, "pre");
    chk("pre.slot", int'(slot), 9);
    chk("pre.dout", int'(dout), 16'hAAAA);
    din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.dout", int'(dout), 0);
    chk("arst.slot", int'(slot), 0);
    chk("arst.locked", int'(locked), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(16'h3C96, 1'b0, "fresh");
    chk("fresh.dout", int'(dout), 16'h3C96);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic dv, fs;
      dv = ($urandom_range(0, 3) != 0);
      fs = ($urandom_range(0, 19) == 0) || (m_locked && q.size() == 0
            && $urandom_range(0, 7) != 0) || (!m_locked
            && $urandom_range(0, 3) == 0);
      step(dv, 1'($urandom), fs, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
